// File: rtl/pwm_fade.sv
// pwm_fade: ramps a duty level toward a commanded target at a programmable rate.
// Define PWM_FADE_GAMMA_EN to add a registered gamma stage (duty = level^2 >> WIDTH).
module pwm_fade #(
    parameter int WIDTH     = 10,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_stb,
    input  logic [WIDTH-1:0]     wr_target,
    input  logic [DIV_WIDTH-1:0] wr_div,
    input  logic [WIDTH-1:0]     wr_step,
    output logic [WIDTH-1:0]     duty,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     level, level_n, target, step;
    logic [DIV_WIDTH-1:0] div, presc, presc_n;
    logic [WIDTH:0]       diff, delta;
    logic                 noop, noop_n, fin, done_r;

    always_comb begin
        diff    = state == UP ? {1'b0, target} - {1'b0, level} : {1'b0, level} - {1'b0, target};
        delta   = {1'b0, step} < diff ? {1'b0, step} : diff;
        state_n = state;
        level_n = level;
        presc_n = presc;
        noop_n  = 1'b0;
        fin     = 1'b0;
        if (wr_stb) begin
            // a new command always wins, even over a completing tick
            state_n = wr_target > level ? UP : wr_target < level ? DOWN : IDLE;
            presc_n = wr_div;
            noop_n  = wr_target == level;
        end else if (state != IDLE) begin
            if (presc == '0) begin
                level_n = state == UP ? level + WIDTH'(delta) : level - WIDTH'(delta);
                presc_n = div;
                if (level_n == target) begin
                    state_n = IDLE;
                    fin     = 1'b1;
                end
            end else begin
                presc_n = presc - DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            level  <= '0;
            target <= '0;
            div    <= '0;
            step   <= '0;
            presc  <= '0;
            noop   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            level  <= level_n;
            presc  <= presc_n;
            noop   <= noop_n;
            done_r <= fin | noop;
            if (wr_stb) begin
                target <= wr_target;
                div    <= wr_div;
                step   <= wr_step == '0 ? WIDTH'(1) : wr_step;
            end
        end
    end

`ifdef PWM_FADE_GAMMA_EN
    logic [2*WIDTH-1:0] sq;
    assign sq = level * level;
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            duty <= WIDTH'(sq >> WIDTH);
            busy <= state != IDLE;
            done <= done_r;
        end
    end
`else
    assign duty = level;
    assign busy = state != IDLE;
    assign done = done_r;
`endif
endmodule

// File: doc/pwm_fade.md
PWM_FADE -- requirements
Module: pwm_fade

Interface
REQ-001 SHALL have parameter WIDTH, default 10: duty width, matching the downstream pwm cfg_val width.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: fade-rate prescaler width.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset (synchronous, active-high).
REQ-005 SHALL have port wr_stb  input  1  one-cycle command strobe; latches wr_target, wr_div and wr_step.
REQ-006 SHALL have port wr_target  input  WIDTH  ramp end value.
REQ-007 SHALL have port wr_div  input  DIV_WIDTH  tick period minus one (clk cycles).
REQ-008 SHALL have port wr_step  input  WIDTH  duty increment per tick; 0 is treated as 1.
REQ-009 SHALL have port duty  output  WIDTH  registered duty value feeding pwm cfg_val.
REQ-010 SHALL have port busy  output  1  high while a ramp is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a ramp completes.

Function
REQ-012 SHALL implement states IDLE, UP and DOWN. Transitions take effect on the edge that samples wr_stb.
- wr_target > current level -> UP.
- wr_target < current level -> DOWN.
- wr_target = current level -> IDLE.
REQ-013 SHALL, on the edge that samples wr_stb, load the prescaler with wr_div; a tick occurs each cycle the prescaler is 0 while in UP/DOWN, and the prescaler then reloads with the latched div.
REQ-014 SHALL, on each tick, move the level toward target by min(step, |target - level|), computed in WIDTH+1 bits, so the level never overshoots, wraps or saturates past target.
REQ-015 SHALL enter IDLE, deassert busy and pulse done for exactly one cycle on the edge where the level becomes equal to target.
REQ-016 SHALL, for wr_stb with target equal to the current level, keep busy low and pulse done one cycle after the strobe edge.
REQ-017 SHALL, for wr_stb during UP/DOWN, retarget from the current level with no jump. The new div/step apply immediately and no done pulse is issued for the abandoned ramp.
REQ-018 SHALL, with wr_div = 0, tick every cycle in UP/DOWN; first level change occurs wr_div+1 cycles after the strobe edge.
REQ-019 SHALL, if wr_stb coincides with a completing tick, give the strobe priority: no done pulse, new command applied.
REQ-020 SHALL accept wr_stb in every cycle; there is no back-pressure.

Reset
REQ-021 SHALL, while rst is high, force state IDLE, level 0, latched target/div/step 0, prescaler 0, duty 0, busy 0, done 0; wr_stb is ignored.
REQ-022 SHALL abandon any ramp on reset mid-operation without emitting done.

Configuration
REQ-023 SHALL support macro PWM_FADE_GAMMA_EN.
- Defined: duty is a registered gamma correction of the level, duty = (level*level) >> WIDTH. This adds one cycle of latency to duty, and done/busy are delayed one cycle to stay aligned with duty.
- Undefined: duty equals the level register directly, with no multiplier.

Verification
REQ-024 SHALL test reset with WIDTH=10: after rst, duty=0, busy=0, done=0; a wr_stb held high during rst has no effect.
REQ-025 SHALL test an up-ramp, gamma off: from level 0, wr_stb with target=8, div=2, step=3 -> duty 3 at strobe+3 cycles, 6 at +6, 8 at +9 (clamped); done pulses at +9; busy high from +1 through +8.
REQ-026 SHALL test a down-ramp with div=0: from 8, target=0, step=0 -> duty decrements by 1 every cycle, reaching 0 at +8; single done pulse.
REQ-027 SHALL test a no-op command: level 5, wr_stb target=5 -> busy stays 0, duty stays 5, done pulses once at +1.
REQ-028 SHALL test retarget: ramping 0->1000 with step=1, div=0, new wr_stb target=10 at level 20 -> DOWN from 20 with no discontinuity; exactly one done pulse, when duty reaches 10.
REQ-029 SHALL test gamma, PWM_FADE_GAMMA_EN defined: level 512 -> duty 256 one cycle later; level 1023 -> duty 1022; done coincident with the final duty update.
